// File: rtl/kb_code_fifo.sv
// PS/2 key-release code FIFO: stores {scan code, ASCII} pairs translated at push time,
// first-word fall-through head, sticky overflow flag for codes dropped while full.
`timescale 1ns/1ps

module kb_code_fifo #(
  parameter int ADDR_W = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            got_code_tick,
  input  logic [7:0]      scan_code,
  input  logic            rd,
  input  logic            clr_ovf,
  output logic [7:0]      key_code,
  output logic [7:0]      ascii,
  output logic            empty,
  output logic            full,
  output logic [ADDR_W:0] count,
  output logic            overflow
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [15:0]       mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              ovf_q,    ovf_d;
  logic              armed_q;
  logic              do_push, do_pop, drop;
  logic [15:0]       head;

  function automatic logic [7:0] to_ascii(input logic [7:0] code);
    case (code)
      8'h1C: return 8'h41;  8'h32: return 8'h42;  8'h21: return 8'h43;
      8'h23: return 8'h44;  8'h24: return 8'h45;  8'h2B: return 8'h46;
      8'h34: return 8'h47;  8'h33: return 8'h48;  8'h43: return 8'h49;
      8'h3B: return 8'h4A;  8'h42: return 8'h4B;  8'h4B: return 8'h4C;
      8'h3A: return 8'h4D;  8'h31: return 8'h4E;  8'h44: return 8'h4F;
      8'h4D: return 8'h50;  8'h15: return 8'h51;  8'h2D: return 8'h52;
      8'h1B: return 8'h53;  8'h2C: return 8'h54;  8'h3C: return 8'h55;
      8'h2A: return 8'h56;  8'h1D: return 8'h57;  8'h22: return 8'h58;
      8'h35: return 8'h59;  8'h1A: return 8'h5A;
      8'h45: return 8'h30;  8'h16: return 8'h31;  8'h1E: return 8'h32;
      8'h26: return 8'h33;  8'h25: return 8'h34;  8'h2E: return 8'h35;
      8'h36: return 8'h36;  8'h3D: return 8'h37;  8'h3E: return 8'h38;
      8'h46: return 8'h39;
      8'h29: return 8'h20;  8'h5A: return 8'h0D;  8'h66: return 8'h08;
      8'h76: return 8'h1B;
      default: return 8'h3F;
    endcase
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign count    = count_q;
  assign overflow = ovf_q;

  // armed_q is low for the first edge after reset release, so a tick landing on
  // that edge is ignored whichever way the release races the clock.
  assign do_pop  = rd && !empty;
  assign do_push = got_code_tick && armed_q && (!full || do_pop);
  assign drop    = got_code_tick && armed_q && full && !rd;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      armed_q  <= 1'b1;
    end
  end

  // NOTE: storage has no reset; stale entries are masked by empty on the outputs.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {scan_code, to_ascii(scan_code)};
  end

  assign head     = mem_q[rd_ptr_q];
  assign key_code = empty ? 8'h00 : head[15:8];
  assign ascii    = empty ? 8'h00 : head[7:0];

endmodule

// File: tb/tb_kb_code_fifo.sv
// Bench for kb_code_fifo: table of {scan code, expected ASCII} vectors fed through a
// scoreboard queue, plus hand-written sequences for reset, full/overflow and wrap cases.
`timescale 1ns/1ps

module tb_kb_code_fifo;

  localparam int DEPTH = 8;
  localparam int NVEC  = 44;

  typedef struct {
    logic [7:0] code;
    logic [7:0] exp_ascii;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       got_code_tick;
  logic [7:0] scan_code;
  logic       rd;
  logic       clr_ovf;
  logic [7:0] key_code;
  logic [7:0] ascii;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overflow;

  int   total = 0;
  int   bad   = 0;
  vec_t vec [NVEC];
  vec_t sb [$];
  bit   m_ovf = 1'b0;

  kb_code_fifo #(.ADDR_W(3)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .got_code_tick(got_code_tick),
    .scan_code    (scan_code),
    .rd           (rd),
    .clr_ovf      (clr_ovf),
    .key_code     (key_code),
    .ascii        (ascii),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic tick, input logic [7:0] code, input logic r, input logic clr);
    got_code_tick = tick;
    scan_code     = code;
    rd            = r;
    clr_ovf       = clr;
    @(posedge clk);
    #1;
    got_code_tick = 1'b0;
    scan_code     = 8'h00;
    rd            = 1'b0;
    clr_ovf       = 1'b0;
  endtask

  // One clock of stimulus; the queue holds what the FIFO should contain afterwards.
  task automatic op(input logic tick, input logic [7:0] code, input logic [7:0] asc,
                    input logic r, input logic clr);
    vec_t e;
    bit   pop_ok, push_ok, drop;
    pop_ok  = r && (sb.size() != 0);
    push_ok = tick && ((sb.size() < DEPTH) || pop_ok);
    drop    = tick && !push_ok;
    if (pop_ok) begin
      e = sb.pop_front();
      check("pop_key_code", key_code, e.code);
      check("pop_ascii", ascii, e.exp_ascii);
    end
    if (push_ok) sb.push_back('{code, asc});
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    cycle(tick, code, r, clr);
    check("count", count, sb.size());
    check("overflow", overflow, m_ovf);
    check("empty", empty, sb.size() == 0);
    check("full", full, sb.size() == DEPTH);
    if (sb.size() != 0) begin
      check("head_key_code", key_code, sb[0].code);
      check("head_ascii", ascii, sb[0].exp_ascii);
    end else begin
      check("empty_key_code", key_code, 8'h00);
      check("empty_ascii", ascii, 8'h00);
    end
  endtask

  task automatic drain();
    while (sb.size() != 0) op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    logic [7:0] exp32 [5];

    vec = '{
      '{8'h1C, 8'h41}, '{8'h32, 8'h42}, '{8'h21, 8'h43}, '{8'h23, 8'h44},
      '{8'h24, 8'h45}, '{8'h2B, 8'h46}, '{8'h34, 8'h47}, '{8'h33, 8'h48},
      '{8'h43, 8'h49}, '{8'h3B, 8'h4A}, '{8'h42, 8'h4B}, '{8'h4B, 8'h4C},
      '{8'h3A, 8'h4D}, '{8'h31, 8'h4E}, '{8'h44, 8'h4F}, '{8'h4D, 8'h50},
      '{8'h15, 8'h51}, '{8'h2D, 8'h52}, '{8'h1B, 8'h53}, '{8'h2C, 8'h54},
      '{8'h3C, 8'h55}, '{8'h2A, 8'h56}, '{8'h1D, 8'h57}, '{8'h22, 8'h58},
      '{8'h35, 8'h59}, '{8'h1A, 8'h5A},
      '{8'h45, 8'h30}, '{8'h16, 8'h31}, '{8'h1E, 8'h32}, '{8'h26, 8'h33},
      '{8'h25, 8'h34}, '{8'h2E, 8'h35}, '{8'h36, 8'h36}, '{8'h3D, 8'h37},
      '{8'h3E, 8'h38}, '{8'h46, 8'h39},
      '{8'h29, 8'h20}, '{8'h5A, 8'h0D}, '{8'h66, 8'h08}, '{8'h76, 8'h1B},
      '{8'h0E, 8'h3F}, '{8'h00, 8'h3F}, '{8'hF0, 8'h3F}, '{8'hFF, 8'h3F}
    };
    exp32 = '{8'h30, 8'h31, 8'h20, 8'h0D, 8'h3F};

    reset_n       = 1'b0;
    got_code_tick = 1'b0;
    scan_code     = 8'h00;
    rd            = 1'b0;
    clr_ovf       = 1'b0;

    // Reset state before any clock edge, then held across an edge with a tick.
    #3;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_key_code", key_code, 8'h00);
    check("rst_ascii", ascii, 8'h00);
    got_code_tick = 1'b1;
    scan_code     = 8'h1C;
    @(posedge clk);
    #1;
    check("rst_hold_count", count, 0);

    // Tick coincident with the reset release edge must be dropped.
    @(posedge clk);
    reset_n = 1'b1;
    #1;
    got_code_tick = 1'b0;
    scan_code     = 8'h00;
    check("release_count", count, 0);
    check("release_empty", empty, 1);
    op(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Single push, fall-through head, single pop.
    op(1'b1, 8'h1C, 8'h41, 1'b0, 1'b0);
    check("one_key_code", key_code, 8'h1C);
    check("one_ascii", ascii, 8'h41);
    check("one_count", count, 1);
    check("one_empty", empty, 0);
    op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("one_pop_empty", empty, 1);
    check("one_pop_ascii", ascii, 8'h00);

    // Digit / special / unknown ordering.
    op(1'b1, 8'h45, 8'h30, 1'b0, 1'b0);
    op(1'b1, 8'h16, 8'h31, 1'b0, 1'b0);
    op(1'b1, 8'h29, 8'h20, 1'b0, 1'b0);
    op(1'b1, 8'h5A, 8'h0D, 1'b0, 1'b0);
    op(1'b1, 8'h0E, 8'h3F, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("seq_ascii", ascii, exp32[i]);
      op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    end

    // Full translation table in bursts of up to DEPTH entries.
    for (int i = 0; i < NVEC; i++) begin
      op(1'b1, vec[i].code, vec[i].exp_ascii, 1'b0, 1'b0);
      if (sb.size() == DEPTH || i == NVEC - 1) drain();
    end

    // Nine pushes with no reads: the ninth is dropped and flags overflow.
    for (int i = 0; i < 9; i++) begin
      op(1'b1, vec[i].code, vec[i].exp_ascii, 1'b0, 1'b0);
      if (i == 7) begin
        check("fill_full", full, 1);
        check("fill_count", count, 8);
        check("fill_no_ovf", overflow, 0);
      end
    end
    check("ninth_ovf", overflow, 1);
    op(1'b1, 8'h76, 8'h1B, 1'b0, 1'b1);
    check("set_wins_ovf", overflow, 1);
    op(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    check("clr_ovf", overflow, 0);

    // Simultaneous push+pop when full: no drop, new code emerges last.
    op(1'b1, 8'h32, 8'h42, 1'b1, 1'b0);
    check("full_rw_count", count, 8);
    check("full_rw_ovf", overflow, 0);
    for (int i = 0; i < 7; i++) op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("last_key_code", key_code, 8'h32);
    check("last_ascii", ascii, 8'h42);
    op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Set overflow, drain, push three, then reset between edges.
    for (int i = 10; i < 19; i++) op(1'b1, vec[i].code, vec[i].exp_ascii, 1'b0, 1'b0);
    drain();
    for (int i = 20; i < 23; i++) op(1'b1, vec[i].code, vec[i].exp_ascii, 1'b0, 1'b0);
    check("pre_rst_ovf", overflow, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_key_code", key_code, 8'h00);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_full", full, 0);
    sb.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    op(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Pop on empty is ignored; push+pop on empty keeps only the push.
    op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("rd_empty_count", count, 0);
    op(1'b1, 8'h4D, 8'h50, 1'b1, 1'b0);
    check("empty_rw_count", count, 1);
    op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

    // Interleaved traffic across several pointer wraps.
    for (int i = 0; i < 20; i++) begin
      op(1'b1, vec[(i * 7) % NVEC].code, vec[(i * 7) % NVEC].exp_ascii, 1'(i % 2), 1'b0);
      if (i % 4 == 3) op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    end
    drain();
    op(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    check("final_rd_empty_count", count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kb_code_fifo.md
KB_CODE_FIFO -- requirements
Module: kb_code_fifo

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 3, FIFO address width (depth = 2**ADDR_W = 8 entries).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port got_code_tick  input  1  one-cycle strobe: scan_code holds a new key-release scan code.
REQ-005 The block SHALL have port scan_code  input  8  raw PS/2 set-2 scan code, valid only while got_code_tick=1.
REQ-006 The block SHALL have port rd  input  1  pop request for the head entry.
REQ-007 The block SHALL have port clr_ovf  input  1  one-cycle clear for the overflow flag.
REQ-008 The block SHALL have port key_code  output  8  raw scan code of the head entry.
REQ-009 The block SHALL have port ascii  output  8  ASCII translation of the head entry.
REQ-010 The block SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-011 The block SHALL have port full  output  1  FIFO holds 2**ADDR_W entries.
REQ-012 The block SHALL have port count  output  ADDR_W+1  number of stored entries.
REQ-013 The block SHALL have port overflow  output  1  sticky flag: a code was dropped.

Function
REQ-014 Push: on an edge with got_code_tick=1 and no drop condition, the block SHALL write {scan_code, translated ASCII} at the write pointer and advance it modulo depth.
REQ-015 The block SHALL translate in the push cycle (not the read cycle): letters A-Z map to uppercase 0x41-0x5A, digits 0-9 to 0x30-0x39, 0x29->0x20, 0x5A->0x0D, 0x66->0x08, 0x76->0x1B, every other code -> 0x3F ('?').
REQ-016 The letter table SHALL be: A1C B32 C21 D23 E24 F2B G34 H33 I43 J3B K42 L4B M3A N31 O44 P4D Q15 R2D S1B T2C U3C V2A W1D X22 Y35 Z1A.
REQ-017 The digit table SHALL be: 0:45 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46.
REQ-018 Pop: on an edge with rd=1 and empty=0, the block SHALL advance the read pointer modulo depth; rd while empty SHALL be ignored without error.
REQ-019 key_code/ascii SHALL be the entry at the read pointer when empty=0 and 8'h00 when empty=1; first-word fall-through, no read latency.
REQ-020 The block SHALL give one cycle of latency from push: an entry pushed at edge N SHALL be visible on key_code/ascii/count after edge N.
REQ-021 count SHALL increment on push-only, decrement on pop-only, and stay unchanged on simultaneous push+pop.
REQ-022 empty SHALL equal (count==0) and full SHALL equal (count==2**ADDR_W), both derived from registered state.
REQ-023 Full with got_code_tick=1 and rd=0: the block SHALL drop the code, leave pointers and count unchanged, and set overflow at that edge.
REQ-024 Full with got_code_tick=1 and rd=1: the block SHALL do both pop and push, with no drop and count staying at max.
REQ-025 Empty with got_code_tick=1 and rd=1: the block SHALL ignore the pop, perform the push, and set count to 1.
REQ-026 overflow SHALL clear on clr_ovf=1; if set and clear coincide, set SHALL win.
REQ-027 Pointers SHALL wrap from 2**ADDR_W-1 to 0 with no effect on ordering.

Reset
REQ-028 While reset_n=0, regardless of clk, the block SHALL hold pointers=0, count=0, overflow=0, empty=1, full=0, key_code=0, ascii=0.
REQ-029 Storage array contents SHALL need no reset and SHALL never be visible while empty=1.
REQ-030 Reset asserted mid-operation SHALL discard all stored entries; a got_code_tick coincident with reset release edge SHALL be ignored.

Verification
REQ-031 Push 0x1C, next cycle: the bench SHALL check key_code=0x1C, ascii=0x41, count=1, empty=0; pulse rd and then check empty=1, ascii=0x00.
REQ-032 Push 0x45,0x16,0x29,0x5A,0x0E: the bench SHALL pop and check ascii sequence 0x30,0x31,0x20,0x0D,0x3F in order.
REQ-033 Push 9 codes with no reads: the bench SHALL check full=1 after 8, count=8, overflow=1 after 9th, and that the 9th code is absent on pop-out.
REQ-034 When full, the bench SHALL apply push 0x32 with rd=1 same cycle and check count stays 8, overflow stays 0, and 0x32 (ascii 0x42) emerges last.
REQ-035 Push 3 codes, then assert reset_n=0 between clock edges: the bench SHALL check immediately that count=0, empty=1, key_code=0, and that overflow cleared.
REQ-036 Perform 20 push/pop pairs with interleaving: the bench SHALL check order is preserved across pointer wrap and that empty on rd produces no count change.
